sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 117 +++++++++++
 tb/tb_sync_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO for CCD sample words between the readout sequencer and the
// USB transmit path. It provides a registered fill level, status flags derived
// from that level, sticky overflow/underflow flags and a synchronous flush.
module sync_fifo #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int AFULL_THRESH  = 240,
    parameter int AEMPTY_THRESH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  write_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  read_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    // Storage is not reset, so it can map onto block RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // The pointers carry one extra bit and wrap modulo 2*DEPTH.
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic full, empty;
    logic wr_acc, rd_acc;

    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);

    // Acceptance looks only at the flags as they stand at the start of the
    // cycle, so a same-cycle read never makes room for a write at full.
    assign wr_acc = write_i && !full  && !flush_i;
    assign rd_acc = read_i  && !empty && !flush_i;

    // Next-state computation for the pointers, the level and the sticky flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) rptr_d = rptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (write_i && full)  ovf_d = 1'b1;
            if (read_i  && empty) udf_d = 1'b1;
        end
    end

    // RAM write port.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= data_i;
    end

    // Control state and the registered read data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            valid_q <= rd_acc;
            if (rd_acc) data_q <= mem_q[rptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign data_o         = data_q;
    assign data_valid_o   = valid_q;
    assign level_o        = level_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (level_q >= AFULL_L);
    assign almost_empty_o = (level_q <= AEMPTY_L);
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int AFT   = 240;
    localparam int AET   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0, write = 1'b0, read = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          data_valid, full, almost_full, empty, almost_empty;
    logic [AW:0]   level;
    logic          overflow, underflow;

    int n_total = 0;
    int n_pass  = 0;

    sync_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .write_i(write),
        .data_i(data_in), .read_i(read), .data_o(data_out),
        .data_valid_o(data_valid), .full_o(full), .almost_full_o(almost_full),
        .empty_o(empty), .almost_empty_o(almost_empty), .level_o(level),
        .overflow_o(overflow), .underflow_o(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: queue of stored words plus the output-side state.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_data;
    logic          m_valid, m_ovf, m_udf;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    task automatic check_model(input string tag);
        int lv;
        lv = mq.size();
        chk({tag, ".level"},     int'(level),        lv);
        chk({tag, ".full"},      int'(full),         int'(lv == DEPTH));
        chk({tag, ".empty"},     int'(empty),        int'(lv == 0));
        chk({tag, ".afull"},     int'(almost_full),  int'(lv >= AFT));
        chk({tag, ".aempty"},    int'(almost_empty), int'(lv <= AET));
        chk({tag, ".valid"},     int'(data_valid),   int'(m_valid));
        chk({tag, ".data"},      int'(data_out),     int'(m_data));
        chk({tag, ".overflow"},  int'(overflow),     int'(m_ovf));
        chk({tag, ".underflow"}, int'(underflow),    int'(m_udf));
    endtask

    task automatic drive(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
        @(negedge clk);
        flush = f; write = w; read = r; data_in = d;
        @(posedge clk);
        #1;
    endtask

    // One cycle against the model; acceptance uses the pre-edge state.
    task automatic op(input logic f, input logic w, input logic r,
                      input logic [DW-1:0] d, input string tag);
        bit was_full, was_empty;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        drive(f, w, r, d);
        m_valid = 1'b0;
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (r && !was_empty) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
            end else if (r) m_udf = 1'b1;
            if (w && !was_full) mq.push_back(d);
            else if (w) m_ovf = 1'b1;
        end
        check_model(tag);
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        flush = 0; write = 0; read = 0; data_in = '0;
    endtask

    typedef struct {
        logic          f, w, r;
        logic [DW-1:0] d;
        int            lvl;
        logic          full, empty, af, ae, vld;
        logic [DW-1:0] dout;
        logic          ovf, udf;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // Hand-computed vectors, starting from reset.
        //            f  w  r  data       lvl fu em af ae vl dout       ov ud
        vecs[0]  = '{0, 0, 0, 16'h0000, 0,  0, 1, 0, 1, 0, 16'h0000, 0, 0};
        vecs[1]  = '{0, 0, 1, 16'h0000, 0,  0, 1, 0, 1, 0, 16'h0000, 0, 1};
        vecs[2]  = '{0, 1, 0, 16'h00A1, 1,  0, 0, 0, 1, 0, 16'h0000, 0, 1};
        vecs[3]  = '{0, 1, 1, 16'h00B2, 1,  0, 0, 0, 1, 1, 16'h00A1, 0, 1};
        vecs[4]  = '{0, 0, 1, 16'h0000, 0,  0, 1, 0, 1, 1, 16'h00B2, 0, 1};
        vecs[5]  = '{0, 0, 0, 16'h0000, 0,  0, 1, 0, 1, 0, 16'h00B2, 0, 1};
        vecs[6]  = '{0, 1, 1, 16'h00C3, 1,  0, 0, 0, 1, 0, 16'h00B2, 0, 1};
        vecs[7]  = '{1, 1, 0, 16'h00D4, 0,  0, 1, 0, 1, 0, 16'h00B2, 0, 0};
        vecs[8]  = '{0, 1, 0, 16'h00E5, 1,  0, 0, 0, 1, 0, 16'h00B2, 0, 0};
        vecs[9]  = '{1, 0, 1, 16'h0000, 0,  0, 1, 0, 1, 0, 16'h00B2, 0, 0};
        vecs[10] = '{0, 0, 1, 16'h0000, 0,  0, 1, 0, 1, 0, 16'h00B2, 0, 1};
        vecs[11] = '{0, 1, 0, 16'h00F6, 1,  0, 0, 0, 1, 0, 16'h00B2, 0, 1};
        vecs[12] = '{0, 0, 1, 16'h0000, 0,  0, 1, 0, 1, 1, 16'h00F6, 0, 1};
        vecs[13] = '{1, 0, 0, 16'h0000, 0,  0, 1, 0, 1, 0, 16'h00F6, 0, 0};

        // Reset values are visible while rst_n is still low.
        #12;
        chk("reset.level",  int'(level),        0);
        chk("reset.empty",  int'(empty),        1);
        chk("reset.aempty", int'(almost_empty), 1);
        chk("reset.full",   int'(full),         0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].f, vecs[i].w, vecs[i].r, vecs[i].d);
            chk($sformatf("vec%0d.level", i),     int'(level),        vecs[i].lvl);
            chk($sformatf("vec%0d.full", i),      int'(full),         int'(vecs[i].full));
            chk($sformatf("vec%0d.empty", i),     int'(empty),        int'(vecs[i].empty));
            chk($sformatf("vec%0d.afull", i),     int'(almost_full),  int'(vecs[i].af));
            chk($sformatf("vec%0d.aempty", i),    int'(almost_empty), int'(vecs[i].ae));
            chk($sformatf("vec%0d.valid", i),     int'(data_valid),   int'(vecs[i].vld));
            chk($sformatf("vec%0d.data", i),      int'(data_out),     int'(vecs[i].dout));
            chk($sformatf("vec%0d.overflow", i),  int'(overflow),     int'(vecs[i].ovf));
            chk($sformatf("vec%0d.underflow", i), int'(underflow),    int'(vecs[i].udf));
        end

        mq.delete();
        m_data = 16'h00F6; m_valid = 0; m_ovf = 0; m_udf = 0;

        // Fill 0..255, then one write too many; a read+write at full.
        for (int i = 0; i < DEPTH; i++) op(0, 1, 0, DW'(i), $sformatf("fill%0d", i));
        op(0, 1, 0, 16'h1234, "fill_over");
        chk("fill_over.level_abs", int'(level), 256);
        op(0, 1, 1, 16'h5555, "full_rw");
        chk("full_rw.level_abs", int'(level), 255);
        op(0, 1, 0, 16'h0100, "refill");

        // Drain: words 1..256 come out in order.
        for (int i = 0; i < DEPTH; i++) begin
            op(0, 0, 1, '0, $sformatf("drain%0d", i));
            chk($sformatf("drain%0d.abs", i), int'(data_out), i + 1);
        end
        op(0, 0, 1, '0, "drain_under");

        // Level 100, 50 cycles of simultaneous read and write.
        op(1, 0, 0, '0, "flush_a");
        for (int i = 0; i < 100; i++) op(0, 1, 0, DW'(16'h2000 + i), "pre100");
        for (int i = 0; i < 50; i++) op(0, 1, 1, DW'(16'h3000 + i), $sformatf("rw100_%0d", i));
        chk("rw100.level_abs", int'(level), 100);
        chk("rw100.last_abs", int'(data_out), 16'h2031);

        // Wrap: three fill-200/drain-200 rounds from pointer 0.
        op(1, 0, 0, '0, "flush_b");
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 200; i++) op(0, 1, 0, DW'(k * 200 + i), $sformatf("wfill%0d_%0d", k, i));
            for (int i = 0; i < 200; i++) op(0, 0, 1, '0, $sformatf("wdrain%0d_%0d", k, i));
        end

        // Flush at level 57 with overflow set and write asserted.
        for (int i = 0; i < DEPTH; i++) op(0, 1, 0, DW'(16'h4000 + i), "ffill");
        op(0, 1, 0, 16'hDEAD, "fover");
        for (int i = 0; i < DEPTH - 57; i++) op(0, 0, 1, '0, "fdrain");
        chk("pre_flush.level_abs", int'(level), 57);
        op(1, 1, 0, 16'hBEEF, "flush57");
        chk("flush57.data_abs", int'(data_out), 16'h40C6);
        op(0, 0, 1, '0, "post_flush_read");

        // Asynchronous reset mid-stream at level 37.
        for (int i = 0; i < 37; i++) op(0, 1, 0, DW'(16'h5000 + i), "r37");
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("arst.level",  int'(level),        0);
        chk("arst.empty",  int'(empty),        1);
        chk("arst.aempty", int'(almost_empty), 1);
        chk("arst.full",   int'(full),         0);
        chk("arst.afull",  int'(almost_full),  0);
        chk("arst.data",   int'(data_out),     0);
        chk("arst.valid",  int'(data_valid),   0);
        chk("arst.ovf",    int'(overflow),     0);
        chk("arst.udf",    int'(underflow),    0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_data = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
        op(0, 0, 1, '0, "arst_read");
        chk("arst_read.udf_abs", int'(underflow), 1);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
